// File: rtl/norflash_pkg.sv
// Shared definitions for the APB-to-NOR-flash bridge: command codes,
// register word offsets, request FSM states and default widths.
package norflash_pkg;

  localparam int ASIZE_DEF = 22;
  localparam int DSIZE_DEF = 8;

  localparam logic [2:0] CMD_READ         = 3'd0;
  localparam logic [2:0] CMD_PROGRAM      = 3'd1;
  localparam logic [2:0] CMD_SECTOR_ERASE = 3'd2;
  localparam logic [2:0] CMD_CHIP_ERASE   = 3'd3;

  // Word offsets, i.e. paddr[4:2]
  localparam logic [2:0] OFF_ADDR   = 3'd0;
  localparam logic [2:0] OFF_WDATA  = 3'd1;
  localparam logic [2:0] OFF_CMD    = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_RDATA  = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_t;

  function automatic logic cmd_reserved(input logic [2:0] cmd);
    return !(cmd inside {CMD_READ, CMD_PROGRAM, CMD_SECTOR_ERASE, CMD_CHIP_ERASE});
  endfunction

endpackage

// File: rtl/norflash_req_fsm.sv
// Request/acknowledge handshake toward norflash_ctrl with a request-time
// watchdog; done and timeout are single-cycle pulses in the final REQ cycle.
module norflash_req_fsm
  import norflash_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_ack,
  output logic o_req,
  output logic o_done,
  output logic o_timeout
);

  req_state_t  r_state;
  req_state_t  w_next;
  logic [23:0] r_cnt;
  logic        w_expire;

  // A TIMEOUT of zero never expires
  assign w_expire = (TIMEOUT != 24'd0) && (r_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == IDLE) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 24'd1;
  end

  // Ack takes priority over an expiry in the same cycle
  always_comb begin
    w_next    = r_state;
    o_req     = (r_state == REQ);
    o_done    = 1'b0;
    o_timeout = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next = REQ;
      REQ: begin
        if (i_ack) begin
          o_done = 1'b1;
          w_next = IDLE;
        end else if (w_expire) begin
          o_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: rtl/apb_norflash_bridge.sv
// APB3 register front-end for norflash_ctrl: software loads address, data
// and command, the bridge runs one request and reports done/err status.
module apb_norflash_bridge
  import norflash_pkg::*;
#(
  parameter int          ASIZE   = ASIZE_DEF,
  parameter int          DSIZE   = DSIZE_DEF,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [4:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [2:0]       sys_cmd_o,
  output logic             flash_req_o,
  input  logic             flash_ack_i,
  output logic [ASIZE-1:0] sys_rd_addr_o,
  output logic [ASIZE-1:0] sys_wr_addr_o,
  output logic [DSIZE-1:0] sys_wr_data_o,
  input  logic [DSIZE-1:0] sys_data_i,
  output logic             irq_o
);

  logic [ASIZE-1:0] r_addr;
  logic [DSIZE-1:0] r_wdata;
  logic [DSIZE-1:0] r_rdata;
  logic [2:0]       r_cmd;
  logic             r_done, r_err, r_ie;
  logic [2:0]       w_off;
  logic             w_access, w_busy, w_err, w_wr_en, w_start;
  logic             w_done_pulse, w_to_pulse;
  logic             w_unused;

  assign w_off    = paddr[4:2];
  assign w_access = psel & penable;
  assign w_unused = ^{pwdata, paddr[1:0]};

  // RDATA reads stall until the pending operation has finished
  assign pready = ~(w_access & ~pwrite & (w_off == OFF_RDATA) & w_busy);

  always_comb begin
    w_err = 1'b0;
    if (w_access) begin
      if (w_off > OFF_RDATA) begin
        w_err = 1'b1;
      end else if (pwrite) begin
        case (w_off)
          OFF_ADDR, OFF_WDATA: w_err = w_busy;
          OFF_CMD:             w_err = w_busy | cmd_reserved(pwdata[2:0]);
          default:             w_err = 1'b0;
        endcase
      end
    end
  end

  assign pslverr = w_err;
  assign w_wr_en = w_access & pwrite & pready & ~w_err;
  assign w_start = w_wr_en & (w_off == OFF_CMD);

  norflash_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_start   (w_start),
    .i_ack     (flash_ack_i),
    .o_req     (w_busy),
    .o_done    (w_done_pulse),
    .o_timeout (w_to_pulse)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_cmd   <= '0;
      r_rdata <= '0;
      r_ie    <= 1'b0;
    end else begin
      if (w_wr_en && w_off == OFF_ADDR)   r_addr  <= pwdata[ASIZE-1:0];
      if (w_wr_en && w_off == OFF_WDATA)  r_wdata <= pwdata[DSIZE-1:0];
      if (w_wr_en && w_off == OFF_STATUS) r_ie    <= pwdata[3];
      if (w_start)                        r_cmd   <= pwdata[2:0];
      if (w_done_pulse && r_cmd == CMD_READ) r_rdata <= sys_data_i;
    end
  end

  // Hardware set beats a simultaneous W1C; a new command clears both flags
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_done_pulse)                                         r_done <= 1'b1;
      else if (w_start)                                         r_done <= 1'b0;
      else if (w_wr_en && w_off == OFF_STATUS && pwdata[1])     r_done <= 1'b0;
      if (w_to_pulse)                                           r_err  <= 1'b1;
      else if (w_start)                                         r_err  <= 1'b0;
      else if (w_wr_en && w_off == OFF_STATUS && pwdata[2])     r_err  <= 1'b0;
    end
  end

  always_comb begin
    prdata = '0;
    if (w_access && !pwrite) begin
      case (w_off)
        OFF_ADDR:   prdata = 32'(r_addr);
        OFF_WDATA:  prdata = 32'(r_wdata);
        OFF_STATUS: prdata = {28'd0, r_ie, r_err, r_done, w_busy};
        OFF_RDATA:  prdata = 32'(r_rdata);
        default:    prdata = '0;
      endcase
    end
  end

  assign flash_req_o   = w_busy;
  assign sys_cmd_o     = r_cmd;
  assign sys_rd_addr_o = r_addr;
  assign sys_wr_addr_o = r_addr;
  assign sys_wr_data_o = r_wdata;
  assign irq_o         = (r_done & r_ie) | (r_err & r_ie);

endmodule

// File: tb/tb_apb_norflash_bridge.sv
// Scoreboard bench for apb_norflash_bridge: APB responses and request
// pulse lengths are queued at issue time and checked by monitors.
module tb_apb_norflash_bridge;

  localparam logic [23:0] TO = 24'd24;

  logic        sys_clk, sys_rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [2:0]  sys_cmd_o;
  logic        flash_req_o, flash_ack_i;
  logic [21:0] sys_rd_addr_o, sys_wr_addr_o;
  logic [7:0]  sys_wr_data_o, sys_data_i;
  logic        irq_o;

  typedef struct {
    string       nm;
    logic        wr;
    logic [31:0] data;
    logic        err;
  } apbExp_t;

  apbExp_t apbQ[$];
  int      reqQ[$];
  int      total = 0;
  int      bad   = 0;
  int      waits;

  apb_norflash_bridge #(.ASIZE(22), .DSIZE(8), .TIMEOUT(TO)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .sys_cmd_o     (sys_cmd_o),
    .flash_req_o   (flash_req_o),
    .flash_ack_i   (flash_ack_i),
    .sys_rd_addr_o (sys_rd_addr_o),
    .sys_wr_addr_o (sys_wr_addr_o),
    .sys_wr_data_o (sys_wr_data_o),
    .sys_data_i    (sys_data_i),
    .irq_o         (irq_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input string nm, input logic wr, input logic [4:0] a,
                               input logic [31:0] d, input logic [31:0] expData,
                               input logic expErr, output int nWait);
    apbExp_t e;
    int n;
    e.nm = nm; e.wr = wr; e.data = expData; e.err = expErr;
    apbQ.push_back(e);
    @(posedge sys_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge sys_clk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge sys_clk);
    while (!pready && n < 200) begin
      n++;
      @(negedge sys_clk);
    end
    nWait = n;
    if (!pready) begin
      total++; bad++;
      $display("[TB] FAIL %s_timeout got=pready0 want=pready1", nm);
      void'(apbQ.pop_back());
    end
    @(posedge sys_clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apbWr(input string nm, input logic [4:0] a, input logic [31:0] d, input logic expErr);
    int w;
    applyStimulus(nm, 1'b1, a, d, 32'd0, expErr, w);
  endtask

  task automatic apbRd(input string nm, input logic [4:0] a, input logic [31:0] expData, input logic expErr);
    int w;
    applyStimulus(nm, 1'b0, a, 32'd0, expData, expErr, w);
  endtask

  // Controller model: ack in the n-th cycle of the request
  task automatic ackAfter(input int n, input logic [7:0] data);
    int k;
    k = 0;
    @(negedge sys_clk);
    while (!flash_req_o && k < 100) begin
      k++;
      @(negedge sys_clk);
    end
    if (!flash_req_o) begin
      total++; bad++;
      $display("[TB] FAIL ackNoReq got=req0 want=req1");
    end else begin
      repeat (n - 1) @(negedge sys_clk);
      flash_ack_i = 1'b1;
      sys_data_i  = data;
      @(negedge sys_clk);
      flash_ack_i = 1'b0;
    end
  endtask

  task automatic waitIdle(input string nm);
    int k;
    k = 0;
    @(negedge sys_clk);
    while (flash_req_o && k < 200) begin
      k++;
      @(negedge sys_clk);
    end
    if (flash_req_o) begin
      total++; bad++;
      $display("[TB] FAIL %s_stuck got=req1 want=req0", nm);
    end
  endtask

  // APB response monitor
  initial begin
    apbExp_t e;
    forever begin
      @(negedge sys_clk);
      if (psel && penable && pready) begin
        total++;
        if (apbQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL apbUnexpected got=resp want=none");
        end else begin
          e = apbQ.pop_front();
          if (pslverr !== e.err || (!e.wr && prdata !== e.data)) begin
            bad++;
            $display("[TB] FAIL %s got=data 0x%0h err %0b want=data 0x%0h err %0b",
                     e.nm, prdata, pslverr, e.wr ? prdata : e.data, e.err);
          end
        end
      end
    end
  end

  // Request length monitor
  initial begin
    int hi;
    int ex;
    hi = 0;
    forever begin
      @(negedge sys_clk);
      if (flash_req_o) begin
        hi++;
      end else if (hi > 0) begin
        total++;
        if (reqQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL reqUnexpected got=%0d want=none", hi);
        end else begin
          ex = reqQ.pop_front();
          if (hi != ex) begin
            bad++;
            $display("[TB] FAIL reqLen got=%0d want=%0d", hi, ex);
          end
        end
        hi = 0;
      end
    end
  end

  initial begin
    sys_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; flash_ack_i = 1'b0; sys_data_i = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    checkOutput("rstReq", 32'(flash_req_o), 32'd0);
    checkOutput("rstCmd", 32'(sys_cmd_o), 32'd0);
    checkOutput("rstRdAddr", 32'(sys_rd_addr_o), 32'd0);
    checkOutput("rstWrData", 32'(sys_wr_data_o), 32'd0);
    checkOutput("rstIrq", 32'(irq_o), 32'd0);
    checkOutput("rstPrdata", prdata, 32'd0);
    checkOutput("rstPready", 32'(pready), 32'd1);
    checkOutput("rstSlverr", 32'(pslverr), 32'd0);
    apbRd("rstStatus", 5'h0C, 32'h0, 1'b0);
    apbRd("rstRdata", 5'h10, 32'h0, 1'b0);

    // Read command acked after 10 cycles
    apbWr("wrAddr", 5'h00, 32'h12345, 1'b0);
    checkOutput("rdAddrOut", 32'(sys_rd_addr_o), 32'h12345);
    checkOutput("wrAddrOut", 32'(sys_wr_addr_o), 32'h12345);
    reqQ.push_back(10);
    fork
      ackAfter(10, 8'hA5);
      apbWr("cmdRead", 5'h08, 32'h0, 1'b0);
    join
    waitIdle("t1");
    apbRd("t1Rdata", 5'h10, 32'hA5, 1'b0);
    apbRd("t1Status", 5'h0C, 32'h2, 1'b0);

    // Program with rejected accesses while busy
    apbWr("wrWdata", 5'h04, 32'h3C, 1'b0);
    checkOutput("wrDataOut", 32'(sys_wr_data_o), 32'h3C);
    reqQ.push_back(20);
    fork
      ackAfter(20, 8'hFF);
      begin
        apbWr("cmdProg", 5'h08, 32'h1, 1'b0);
        apbWr("cmdBusy", 5'h08, 32'h2, 1'b1);
        checkOutput("cmdStable", 32'(sys_cmd_o), 32'h1);
        apbRd("busyStatus", 5'h0C, 32'h1, 1'b0);
        apbWr("addrBusy", 5'h00, 32'h1, 1'b1);
        apbWr("wdataBusy", 5'h04, 32'h77, 1'b1);
      end
    join
    waitIdle("t2");
    apbRd("t2Status", 5'h0C, 32'h2, 1'b0);
    apbRd("t2Rdata", 5'h10, 32'hA5, 1'b0);
    apbRd("t2Addr", 5'h00, 32'h12345, 1'b0);
    apbRd("t2Wdata", 5'h04, 32'h3C, 1'b0);

    // Sector erase that times out
    apbWr("ieOn", 5'h0C, 32'h8, 1'b0);
    reqQ.push_back(24);
    apbWr("cmdErase", 5'h08, 32'h2, 1'b0);
    waitIdle("t3");
    apbRd("t3Status", 5'h0C, 32'hC, 1'b0);
    checkOutput("t3Irq", 32'(irq_o), 32'd1);
    apbWr("w1cErr", 5'h0C, 32'hC, 1'b0);
    apbRd("t3Cleared", 5'h0C, 32'h8, 1'b0);
    checkOutput("t3IrqOff", 32'(irq_o), 32'd0);
    apbRd("t3Rdata", 5'h10, 32'hA5, 1'b0);

    // Ack in the final allowed cycle wins over timeout
    reqQ.push_back(24);
    fork
      ackAfter(24, 8'h77);
      apbWr("cmdRace", 5'h08, 32'h0, 1'b0);
    join
    waitIdle("t4");
    apbRd("t4Status", 5'h0C, 32'hA, 1'b0);
    checkOutput("t4Irq", 32'(irq_o), 32'd1);
    apbRd("t4Rdata", 5'h10, 32'h77, 1'b0);
    apbWr("w1cDone", 5'h0C, 32'h2, 1'b0);
    apbRd("t4Cleared", 5'h0C, 32'h0, 1'b0);

    // RDATA read stalls until the read completes
    reqQ.push_back(23);
    fork
      ackAfter(23, 8'h5A);
      begin
        apbWr("cmdRead2", 5'h08, 32'h0, 1'b0);
        repeat (3) @(posedge sys_clk);
        applyStimulus("waitRdata", 1'b0, 5'h10, 32'h0, 32'h5A, 1'b0, waits);
        checkOutput("waitSeen", 32'(waits > 10), 32'd1);
      end
    join
    waitIdle("t5");

    // Reset in the middle of a chip erase
    apbWr("addrMax", 5'h00, 32'h3FFFFF, 1'b0);
    apbWr("wdata11", 5'h04, 32'h11, 1'b0);
    apbWr("ieOn2", 5'h0C, 32'h8, 1'b0);
    reqQ.push_back(6);
    apbWr("cmdChip", 5'h08, 32'h3, 1'b0);
    repeat (5) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    checkOutput("midRstReq", 32'(flash_req_o), 32'd0);
    checkOutput("midRstCmd", 32'(sys_cmd_o), 32'd0);
    checkOutput("midRstAddr", 32'(sys_wr_addr_o), 32'd0);
    checkOutput("midRstData", 32'(sys_wr_data_o), 32'd0);
    checkOutput("midRstIrq", 32'(irq_o), 32'd0);
    apbRd("midRstStatus", 5'h0C, 32'h0, 1'b0);
    apbRd("midRstRdata", 5'h10, 32'h0, 1'b0);
    apbWr("cmdReserved", 5'h08, 32'h7, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1 checkOutput("resNoReq", 32'(flash_req_o), 32'd0);
    apbRd("resStatus", 5'h0C, 32'h0, 1'b0);
    apbRd("cmdReadBack", 5'h08, 32'h0, 1'b0);
    apbRd("unmapRd", 5'h14, 32'h0, 1'b1);
    apbWr("unmapWr", 5'h18, 32'h1, 1'b1);

    repeat (4) @(posedge sys_clk);
    checkOutput("apbQEmpty", 32'(apbQ.size()), 32'd0);
    checkOutput("reqQEmpty", 32'(reqQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
